// File: rtl/ahb_slave_mux.sv
`default_nettype none
// ============================================================================
// Module   : ahb_slave_mux
// Purpose  : AHB-Lite data-phase interconnect with default slave and
//            per-slave wait-state watchdog / quarantine.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_slave_mux #(
    parameter int NSLV    = 8,
    parameter int DW      = 64,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                 HCLK,
    input  logic                 reset,
    input  logic [1:0]           HTRANS,
    input  logic [NSLV-1:0]      HSELS,
    input  logic [NSLV-1:0]      HREADYOUTS,
    input  logic [NSLV-1:0]      HRESPS,
    input  logic [NSLV*DW-1:0]   HRDATAS,
    input  logic [NSLV-1:0]      HungClear,
    output logic [NSLV-1:0]      HSELOUT,
    output logic                 HREADY,
    output logic                 HRESP,
    output logic [DW-1:0]        HRDATA,
    output logic [NSLV-1:0]      Hung,
    output logic                 DecodeErr,
    output logic                 TimeoutErr
);

    localparam int c_SW = (NSLV > 1) ? $clog2(NSLV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SLAVE = 2'd1;
    localparam logic [1:0] S_ERR1  = 2'd2;
    localparam logic [1:0] S_ERR2  = 2'd3;

    logic [1:0]      r_state;
    logic [c_SW-1:0] r_dsel;
    logic [NSLV-1:0] r_hung;
    logic            r_decode_err;
    logic            r_timeout_err;

    logic            w_any;
    logic            w_multi;
    logic            w_onehot;
    logic [c_SW-1:0] w_sel_idx;
    logic            w_slv_rdy;
    logic            w_slv_resp;
    logic [DW-1:0]   w_slv_data;
    logic            w_expire;
    logic [1:0]      w_next_state;
    logic [c_SW-1:0] w_next_dsel;
    logic            w_decode;
    logic            w_timeout;
    logic [NSLV-1:0] w_hung_set;

    assign Hung       = r_hung;
    assign DecodeErr  = r_decode_err;
    assign TimeoutErr = r_timeout_err;

    // Address-phase qualification: a transfer reaches a slave only on a clean one-hot hit
    always_comb begin
        w_any     = 1'b0;
        w_multi   = 1'b0;
        w_sel_idx = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (HSELS[i]) begin
                if (w_any) begin
                    w_multi = 1'b1;
                end
                w_any     = 1'b1;
                w_sel_idx = i[c_SW-1:0];
            end
        end
        w_onehot = w_any & ~w_multi;
        HSELOUT  = w_onehot ? (HSELS & ~r_hung) : '0;
    end

    always_comb begin
        w_slv_rdy  = 1'b0;
        w_slv_resp = 1'b0;
        w_slv_data = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (r_dsel == i[c_SW-1:0]) begin
                w_slv_rdy  = HREADYOUTS[i];
                w_slv_resp = HRESPS[i];
                w_slv_data = HRDATAS[i*DW +: DW];
            end
        end
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        case (r_state)
            S_SLAVE: begin
                HREADY = w_slv_rdy;
                HRESP  = w_slv_resp;
                HRDATA = w_slv_data;
            end
            S_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            S_ERR2: begin
                HRESP  = 1'b1;
            end
            default: begin
                HREADY = 1'b1;
            end
        endcase
    end

    generate
        if (TIMEOUT > 0) begin : g_wdog
            logic [TO_W-1:0] r_cnt;

            assign w_expire = (r_state == S_SLAVE) && !w_slv_rdy &&
                              (r_cnt == TO_W'(TIMEOUT));

            always_ff @(posedge HCLK or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if ((r_state == S_SLAVE) && !w_slv_rdy && !w_expire) begin
                    r_cnt <= r_cnt + TO_W'(1);
                end else begin
                    r_cnt <= '0;
                end
            end
        end else begin : g_no_wdog
            assign w_expire = 1'b0;
        end
    endgenerate

    always_comb begin
        w_next_state = r_state;
        w_next_dsel  = r_dsel;
        w_decode     = 1'b0;
        w_timeout    = 1'b0;
        w_hung_set   = '0;
        case (r_state)
            S_ERR1: begin
                w_next_state = S_ERR2;
            end
            default: begin
                if ((r_state == S_SLAVE) && !w_slv_rdy) begin
                    // Stalled owner: hold unless the watchdog fires
                    if (w_expire) begin
                        w_next_state = S_ERR1;
                        w_timeout    = 1'b1;
                        for (int i = 0; i < NSLV; i++) begin
                            if (r_dsel == i[c_SW-1:0]) begin
                                w_hung_set[i] = 1'b1;
                            end
                        end
                    end
                end else if (HTRANS[1]) begin
                    if (|HSELOUT) begin
                        w_next_state = S_SLAVE;
                        w_next_dsel  = w_sel_idx;
                    end else begin
                        w_next_state = S_ERR1;
                        w_decode     = 1'b1;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_dsel        <= '0;
            r_hung        <= '0;
            r_decode_err  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_dsel        <= w_next_dsel;
            r_hung        <= (r_hung & ~HungClear) | w_hung_set;
            r_decode_err  <= w_decode;
            r_timeout_err <= w_timeout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_slave_mux
// Purpose  : Directed vector table plus randomized run against a
//            transaction-level reference model of ahb_slave_mux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_mux;

    localparam int NSLV    = 8;
    localparam int DW      = 64;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 8;

    localparam logic [1:0] c_NS = 2'b10;
    localparam logic [1:0] c_ID = 2'b00;
    localparam logic [1:0] c_BZ = 2'b01;

    logic                HCLK = 1'b0;
    logic                reset;
    logic [1:0]          HTRANS;
    logic [NSLV-1:0]     HSELS;
    logic [NSLV-1:0]     HREADYOUTS;
    logic [NSLV-1:0]     HRESPS;
    logic [NSLV*DW-1:0]  HRDATAS;
    logic [NSLV-1:0]     HungClear;
    logic [NSLV-1:0]     HSELOUT;
    logic                HREADY;
    logic                HRESP;
    logic [DW-1:0]       HRDATA;
    logic [NSLV-1:0]     Hung;
    logic                DecodeErr;
    logic                TimeoutErr;

    ahb_slave_mux #(
        .NSLV    (NSLV),
        .DW      (DW),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .HCLK       (HCLK),
        .reset      (reset),
        .HTRANS     (HTRANS),
        .HSELS      (HSELS),
        .HREADYOUTS (HREADYOUTS),
        .HRESPS     (HRESPS),
        .HRDATAS    (HRDATAS),
        .HungClear  (HungClear),
        .HSELOUT    (HSELOUT),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .Hung       (Hung),
        .DecodeErr  (DecodeErr),
        .TimeoutErr (TimeoutErr)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [1:0]  htrans;
        logic [7:0]  hsels;
        logic [7:0]  rdy;
        logic [7:0]  resp;
        logic [7:0]  clr;
        logic [7:0]  e_sel;
        logic        e_ready;
        logic        e_resp;
        logic [63:0] e_data;
        logic        e_derr;
        logic        e_terr;
        logic [7:0]  e_hung;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Transaction-level model state
    int          m_owner;
    int          m_err;
    int          m_waits;
    logic        m_derr;
    logic        m_terr;
    logic [7:0]  m_hung;

    function automatic logic [63:0] sdata(input int i);
        return (i == 2) ? 64'hDEAD_BEEF : (64'hC0DE_0000_0000_0000 | 64'(i));
    endfunction

    task automatic add(input logic [1:0] ht, input logic [7:0] hs, input logic [7:0] rd,
                       input logic [7:0] rs, input logic [7:0] cl, input logic [7:0] es,
                       input logic er, input logic ep, input logic [63:0] ed,
                       input logic dd, input logic tt, input logic [7:0] eh);
        vec_t v;
        v.htrans = ht; v.hsels = hs; v.rdy = rd; v.resp = rs; v.clr = cl;
        v.e_sel = es; v.e_ready = er; v.e_resp = ep; v.e_data = ed;
        v.e_derr = dd; v.e_terr = tt; v.e_hung = eh;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] es, input logic er,
                              input logic ep, input logic [63:0] ed, input logic dd,
                              input logic tt, input logic [7:0] eh);
        chk({tag, ".HSELOUT"},    64'(HSELOUT),    64'(es));
        chk({tag, ".HREADY"},     64'(HREADY),     64'(er));
        chk({tag, ".HRESP"},      64'(HRESP),      64'(ep));
        chk({tag, ".HRDATA"},     HRDATA,          ed);
        chk({tag, ".DecodeErr"},  64'(DecodeErr),  64'(dd));
        chk({tag, ".TimeoutErr"}, 64'(TimeoutErr), 64'(tt));
        chk({tag, ".Hung"},       64'(Hung),       64'(eh));
    endtask

    task automatic drive(input logic [1:0] ht, input logic [7:0] hs, input logic [7:0] rd,
                         input logic [7:0] rs, input logic [7:0] cl);
        HTRANS = ht; HSELS = hs; HREADYOUTS = rd; HRESPS = rs; HungClear = cl;
    endtask

    task automatic model_reset();
        m_owner = -1; m_err = 0; m_waits = 0;
        m_derr = 1'b0; m_terr = 1'b0; m_hung = '0;
    endtask

    initial begin
        logic [7:0]  e_sel;
        logic        e_rdy;
        logic        e_rsp;
        logic [63:0] e_dat;
        logic [7:0]  nh;

        reset = 1'b1;
        drive(c_ID, 8'h00, 8'hFF, 8'h00, 8'h00);
        for (int i = 0; i < NSLV; i++) HRDATAS[i*DW +: DW] = sdata(i);

        //      htrans hsels  rdy    resp   clr    sel    rdy  rsp  data          derr terr hung
        add(c_NS, 8'h04, 8'hFF, 8'h00, 8'h00, 8'h04, 1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 8'h00);
        add(c_ID, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 64'hDEAD_BEEF, 1'b0, 1'b0, 8'h00);
        add(c_NS, 8'h20, 8'hFF, 8'h00, 8'h00, 8'h20, 1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++)
            add(c_ID, 8'h00, 8'hDF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, sdata(5), 1'b0, 1'b0, 8'h00);
        add(c_ID, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, sdata(5),     1'b0, 1'b0, 8'h00);
        add(c_NS, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 8'h00);
        add(c_ID, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 64'h0,        1'b1, 1'b0, 8'h00);
        add(c_NS, 8'h03, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 64'h0,        1'b0, 1'b0, 8'h00);
        add(c_ID, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 64'h0,        1'b1, 1'b0, 8'h00);
        add(c_ID, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 64'h0,        1'b0, 1'b0, 8'h00);
        // Slave 1 stalls forever: TIMEOUT+1 waits, then ERR1/ERR2 and quarantine
        add(c_NS, 8'h02, 8'hFD, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++)
            add(c_ID, 8'h00, 8'hFD, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, sdata(1), 1'b0, 1'b0, 8'h00);
        add(c_ID, 8'h00, 8'hFD, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 64'h0,        1'b0, 1'b1, 8'h02);
        add(c_NS, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 64'h0,        1'b0, 1'b0, 8'h02);
        add(c_ID, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 64'h0,        1'b1, 1'b0, 8'h02);
        add(c_ID, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 64'h0,        1'b0, 1'b0, 8'h02);
        // Clear held through a second timeout: the set must win on the abort edge
        add(c_ID, 8'h00, 8'hFF, 8'h00, 8'h02, 8'h00, 1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 8'h02);
        add(c_NS, 8'h02, 8'hFD, 8'h00, 8'h02, 8'h02, 1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++)
            add(c_ID, 8'h00, 8'hFD, 8'h00, 8'h02, 8'h00, 1'b0, 1'b0, sdata(1), 1'b0, 1'b0, 8'h00);
        add(c_ID, 8'h00, 8'hFD, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 64'h0,        1'b0, 1'b1, 8'h02);
        add(c_ID, 8'h00, 8'hFF, 8'h00, 8'h02, 8'h00, 1'b1, 1'b1, 64'h0,        1'b0, 1'b0, 8'h02);
        add(c_NS, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 8'h00);
        add(c_ID, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, sdata(1),     1'b0, 1'b0, 8'h00);
        add(c_BZ, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 8'h00);
        add(c_ID, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 8'h00);
        add(c_ID, 8'h04, 8'hFF, 8'h00, 8'h00, 8'h04, 1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 8'h00);
        add(c_BZ, 8'h04, 8'hFF, 8'h00, 8'h00, 8'h04, 1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 8'h00);
        // Slave-generated ERROR passes straight through
        add(c_NS, 8'h10, 8'hFF, 8'h10, 8'h00, 8'h10, 1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 8'h00);
        add(c_ID, 8'h00, 8'hEF, 8'h10, 8'h00, 8'h00, 1'b0, 1'b1, sdata(4),     1'b0, 1'b0, 8'h00);
        add(c_ID, 8'h00, 8'hFF, 8'h10, 8'h00, 8'h00, 1'b1, 1'b1, sdata(4),     1'b0, 1'b0, 8'h00);

        repeat (2) @(negedge HCLK);
        #1;
        check_outs("reset", 8'h00, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 8'h00);
        @(negedge HCLK);
        reset = 1'b0;

        foreach (tbl[r]) begin
            drive(tbl[r].htrans, tbl[r].hsels, tbl[r].rdy, tbl[r].resp, tbl[r].clr);
            #1;
            check_outs($sformatf("row%0d", r), tbl[r].e_sel, tbl[r].e_ready, tbl[r].e_resp,
                       tbl[r].e_data, tbl[r].e_derr, tbl[r].e_terr, tbl[r].e_hung);
            @(negedge HCLK);
        end

        // Reset asserted during ERR1 must release the bus immediately
        drive(c_NS, 8'h00, 8'hFF, 8'h00, 8'h00);
        @(negedge HCLK);
        drive(c_ID, 8'h00, 8'hFF, 8'h00, 8'h00);
        #1;
        chk("err1_pre.HREADY", 64'(HREADY), 64'h0);
        chk("err1_pre.HRESP",  64'(HRESP),  64'h1);
        reset = 1'b1;
        #1;
        chk("err1_rst.HREADY",    64'(HREADY),    64'h1);
        chk("err1_rst.HRESP",     64'(HRESP),     64'h0);
        chk("err1_rst.DecodeErr", 64'(DecodeErr), 64'h0);
        @(negedge HCLK);
        reset = 1'b0;
        model_reset();

        for (int c = 0; c < 3000; c++) begin
            logic [7:0] hs;
            logic [7:0] rd;
            logic [7:0] rs;
            logic [7:0] cl;
            case ($urandom % 8)
                0, 1, 2, 3, 4: hs = 8'h01 << ($urandom % 8);
                5:             hs = 8'h00;
                6:             hs = (8'h01 << ($urandom % 8)) | (8'h01 << ($urandom % 8));
                default:       hs = 8'($urandom);
            endcase
            for (int i = 0; i < NSLV; i++) begin
                rd[i] = (i >= 6) ? (($urandom % 8) == 0) : (($urandom % 4) != 0);
                rs[i] = (($urandom % 8) == 0);
                cl[i] = (($urandom % 16) == 0);
                HRDATAS[i*DW +: DW] = {$urandom, $urandom};
            end
            drive(2'($urandom), hs, rd, rs, cl);
            #1;

            e_sel = ($countones(hs) == 1) ? (hs & ~m_hung) : 8'h00;
            if (m_err == 1) begin
                e_rdy = 1'b0; e_rsp = 1'b1; e_dat = '0;
            end else if (m_err == 2) begin
                e_rdy = 1'b1; e_rsp = 1'b1; e_dat = '0;
            end else if (m_owner >= 0) begin
                e_rdy = rd[m_owner]; e_rsp = rs[m_owner]; e_dat = HRDATAS[m_owner*DW +: DW];
            end else begin
                e_rdy = 1'b1; e_rsp = 1'b0; e_dat = '0;
            end
            check_outs($sformatf("rnd%0d", c), e_sel, e_rdy, e_rsp, e_dat, m_derr, m_terr, m_hung);

            nh     = m_hung & ~cl;
            m_derr = 1'b0;
            m_terr = 1'b0;
            if (m_err == 1) begin
                m_err = 2;
            end else if (m_owner >= 0 && !rd[m_owner]) begin
                m_waits++;
                if (m_waits == TIMEOUT + 1) begin
                    nh[m_owner] = 1'b1;
                    m_owner = -1;
                    m_err   = 1;
                    m_terr  = 1'b1;
                    m_waits = 0;
                end
            end else begin
                m_owner = -1;
                m_err   = 0;
                m_waits = 0;
                if (HTRANS[1]) begin
                    if (e_sel != 8'h00) begin
                        for (int k = 0; k < NSLV; k++) if (e_sel[k]) m_owner = k;
                    end else begin
                        m_err  = 1;
                        m_derr = 1'b1;
                    end
                end
            end
            m_hung = nh;
            @(negedge HCLK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
